// File: rtl/disp_scan_ctrl_pkg.sv
// disp_pkg: shared constants, FSM state type and width helpers for the display scan controller.
package disp_pkg;
  localparam logic [3:0] CODE_OVF = 4'hE;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;
  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction
  // At least 1 so single-digit or tiny builds still get a legal vector width.
  function automatic int clog2(input int v);
    clog2 = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) clog2 = i + 1;
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: load handshake and scanned digit outputs of the display controller.
interface disp_scan_ctrl_if #(parameter int N_DIGITS = 4, parameter int BIN_W = 16);
  logic en, load, hex_mode, blank_lz, busy, ovf, out_blank;
  logic [BIN_W-1:0] bin_in;
  logic [3:0] out_bcd;
  logic [N_DIGITS-1:0] out_sel;
  modport master (output en, load, bin_in, hex_mode, blank_lz,
                  input busy, ovf, out_bcd, out_blank, out_sel);
  modport slave (input en, load, bin_in, hex_mode, blank_lz,
                 output busy, ovf, out_bcd, out_blank, out_sel);
endinterface

// File: rtl/disp_scan_ctrl_bin2bcd.sv
// bin2bcd_seq: sequential shift-add-3 converter, one bit per cycle for BIN_W cycles after start.
module bin2bcd_seq import disp_pkg::*; #(
  parameter int BIN_W = 16,
  parameter int N_DIGITS = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic done_o,
  output logic [4*N_DIGITS-1:0] bcd_o
);
  localparam int CW = clog2(BIN_W + 1);
  logic [BIN_W-1:0] sh_q;
  logic [4*N_DIGITS-1:0] acc_q, adj;
  logic [CW-1:0] cnt_q;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < N_DIGITS; i++)
      adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      sh_q <= bin_i;
      acc_q <= '0;
      cnt_q <= CW'(BIN_W);
    end else if (cnt_q != '0) begin
      {acc_q, sh_q} <= {adj, sh_q} << 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end
  // done marks the cycle doing the final step; the result is in bcd_o from the next cycle on.
  assign done_o = cnt_q == CW'(1);
  assign bcd_o = acc_q;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: latches a value, converts it to BCD or hex digits and time-multiplexes them one-hot.
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W = 16,
  parameter int SCAN_DIV = 1000
) (
  input logic clk,
  input logic resetn,
  disp_scan_ctrl_if.slave bus
);
  localparam int DW = 4 * N_DIGITS;
  localparam int IW = clog2(N_DIGITS);
  localparam int PW = clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] RELOAD = PW'(SCAN_DIV - 1);
  localparam logic [63:0] LIMIT = pow10(N_DIGITS) - 64'd1;
  state_e state_q;
  logic [BIN_W-1:0] bin_q;
  logic hex_q, blz_q, ovfp_q, busy_q, ovf_q, out_blank_q;
  logic [DW-1:0] disp_q, disp_d, bcd, new_disp;
  logic [BIN_W+DW-1:0] ext;
  logic [N_DIGITS-1:0] blank_q, blank_d, new_blank, out_sel_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] out_bcd_q;
  logic over, start, done, commit, tick, nz;
  assign over = 64'(bus.bin_in) > LIMIT;
  assign start = state_q == IDLE && bus.load && !bus.hex_mode && !over;
  bin2bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_conv (
    .clk(clk), .resetn(resetn), .start_i(start), .bin_i(bus.bin_in), .done_o(done), .bcd_o(bcd)
  );
  always_comb begin
    ext = {{DW{1'b0}}, bin_q};
    new_disp = hex_q ? ext[DW-1:0] : ovfp_q ? {N_DIGITS{CODE_OVF}} : bcd;
    new_blank = '0;
    nz = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      nz = nz | (bcd[4*i+:4] != 4'd0);
      new_blank[i] = blz_q && !hex_q && !ovfp_q && !nz;
    end
    commit = state_q == COMMIT;
    disp_d = commit ? new_disp : disp_q;
    blank_d = commit ? new_blank : blank_q;
    tick = bus.en && pre_q == '0;
    pre_d = !bus.en ? pre_q : tick ? RELOAD : pre_q - PW'(1);
    idx_d = !tick ? idx_q : idx_q == LAST ? '0 : idx_q + IW'(1);
  end
  // Digit outputs come from next-state values so select and code change on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bin_q <= '0;
      hex_q <= 1'b0;
      blz_q <= 1'b0;
      ovfp_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
      disp_q <= '0;
      blank_q <= '0;
      idx_q <= '0;
      pre_q <= RELOAD;
      out_sel_q <= N_DIGITS'(1);
      out_bcd_q <= '0;
      out_blank_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      blank_q <= blank_d;
      idx_q <= idx_d;
      pre_q <= pre_d;
      out_sel_q <= N_DIGITS'(1) << idx_d;
      out_bcd_q <= disp_d[4*idx_d+:4];
      out_blank_q <= blank_d[idx_d];
      case (state_q)
        IDLE: if (bus.load) begin
          bin_q <= bus.bin_in;
          hex_q <= bus.hex_mode;
          blz_q <= bus.blank_lz;
          ovfp_q <= !bus.hex_mode && over;
          busy_q <= 1'b1;
          state_q <= bus.hex_mode || over ? COMMIT : CONV;
        end
        CONV: if (done) state_q <= COMMIT;
        COMMIT: begin
          ovf_q <= ovfp_q;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.ovf = ovf_q;
  assign bus.out_bcd = out_bcd_q;
  assign bus.out_blank = out_blank_q;
  assign bus.out_sel = out_sel_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed loads with a scoreboard; a monitor checks each commit over a full scan.
module tb_disp_scan_ctrl;
  typedef struct {
    logic [15:0] dig;
    logic [3:0] blank;
    logic ovf;
    int lat;
    int lcyc;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t q[$];
  disp_scan_ctrl_if #(.N_DIGITS(4), .BIN_W(16)) bus ();
  disp_scan_ctrl #(.N_DIGITS(4), .BIN_W(16), .SCAN_DIV(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
    chk({tag, "_bcd"}, bus.out_bcd, 0);
    chk({tag, "_blank"}, bus.out_blank, 0);
    chk({tag, "_sel"}, bus.out_sel, 4'b0001);
  endtask

  task automatic do_load(input logic [15:0] v, input logic hx, input logic blz, input logic [15:0] dig,
                         input logic [3:0] bl, input logic ov, input int lat, input logic extra);
    int d0, t;
    exp_t e;
    d0 = done_cnt;
    @(negedge clk);
    bus.bin_in = v;
    bus.hex_mode = hx;
    bus.blank_lz = blz;
    bus.load = 1'b1;
    e.dig = dig; e.blank = bl; e.ovf = ov; e.lat = lat; e.lcyc = cyc;
    q.push_back(e);
    @(negedge clk);
    bus.load = 1'b0;
    if (extra) begin
      repeat (3) @(negedge clk);
      bus.bin_in = 16'd1234;
      bus.hex_mode = 1'b0;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: no commit for value %0h within %0d cycles", v, t);
      q.delete();
    end
  endtask

  // Monitor: on each busy fall, pop the expected display and check it over one full scan rotation.
  initial begin
    logic bprev;
    exp_t e;
    int k;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) bprev = 1'b0;
      else begin
        if (bprev && !bus.busy) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: busy fell with nothing pending at cycle %0d", cyc);
          end else begin
            e = q.pop_front();
            chk("latency", cyc - e.lcyc, e.lat);
            chk("ovf", bus.ovf, e.ovf);
            for (int n = 0; n < 16; n++) begin
              if (n > 0) @(negedge clk);
              k = 0;
              for (int j = 0; j < 4; j++) if (bus.out_sel[j]) k = j;
              chk("onehot", $onehot(bus.out_sel), 1);
              chk("digit", bus.out_bcd, e.dig[4*k+:4]);
              chk("blank", bus.out_blank, e.blank[k]);
            end
            done_cnt++;
          end
        end
        bprev = bus.busy;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.bin_in = '0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_reset("rst_hold");
    end
    resetn = 1'b1;
    chk("scan_0", bus.out_sel, 4'b0001);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      chk("scan", bus.out_sel, 4'b0001 << ((k / 4) % 4));
    end
    bus.en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("en_hold", bus.out_sel, 4'b0001);
    end
    bus.en = 1'b1;
    @(negedge clk);
    chk("en_resume", bus.out_sel, 4'b0010);
    do_load(16'd4660, 1'b0, 1'b0, 16'h4660, 4'b0000, 1'b0, 18, 1'b1);
    do_load(16'd10000, 1'b0, 1'b0, 16'hEEEE, 4'b0000, 1'b1, 2, 1'b0);
    do_load(16'd9999, 1'b0, 1'b0, 16'h9999, 4'b0000, 1'b0, 18, 1'b0);
    do_load(16'h1234, 1'b1, 1'b0, 16'h1234, 4'b0000, 1'b0, 2, 1'b0);
    do_load(16'h0012, 1'b1, 1'b1, 16'h0012, 4'b0000, 1'b0, 2, 1'b0);
    do_load(16'd7, 1'b0, 1'b1, 16'h0007, 4'b1110, 1'b0, 18, 1'b0);
    do_load(16'd0, 1'b0, 1'b1, 16'h0000, 4'b1110, 1'b0, 18, 1'b0);
    do_load(16'hABCD, 1'b1, 1'b0, 16'hABCD, 4'b0000, 1'b0, 2, 1'b0);
    @(negedge clk);
    bus.bin_in = 16'd4660;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("conv_busy", bus.busy, 1);
    repeat (7) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset("abort");
    @(negedge clk);
    #2 resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_abort_bcd", bus.out_bcd, 0);
      chk("post_abort_busy", bus.busy, 0);
      chk("post_abort_blank", bus.out_blank, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
